// File: rtl/hpdcache_l15_resp_route_table.sv
// Transaction-ID allocator and response routing table for the L1.5 response path.
// Allocates the lowest free ID per request and routes responses to the recorded port.
module hpdcache_l15_resp_route_table #(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned ID_WIDTH     = 3,
  parameter int unsigned PORTID_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PORTID_WIDTH-1:0] req_portid_i,
  output logic [ID_WIDTH-1:0]     req_id_o,
  input  logic                    resp_valid_i,
  output logic                    resp_ready_o,
  input  logic [ID_WIDTH-1:0]     resp_id_i,
  input  logic                    resp_last_i,
  output logic                    demux_valid_o,
  output logic [PORTID_WIDTH-1:0] demux_sel_o,
  input  logic                    demux_ready_i,
  output logic [ID_WIDTH:0]       outstanding_o,
  output logic                    err_o
);

  localparam int unsigned RT_DEPTH = 2 ** ID_WIDTH;

  logic [RT_DEPTH-1:0]     busy_q, busy_d;
  logic [PORTID_WIDTH-1:0] port_q [RT_DEPTH];
  logic [PORTID_WIDTH-1:0] port_d [RT_DEPTH];
  logic [ID_WIDTH:0]       cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    any_free;
  logic [ID_WIDTH-1:0]     free_id;
  logic                    hit;
  logic                    alloc;
  logic                    release_id;

  // Lowest-index free entry; scanning downwards lets the lowest index win.
  always_comb begin
    free_id = '0;
    for (int i = RT_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_id = ID_WIDTH'(i);
    end
  end

  assign any_free    = ~&busy_q;
  assign req_ready_o = any_free & ~rst_i;
  assign req_id_o    = req_ready_o ? free_id : '0;

  // Reset presents an empty table to the response path.
  assign hit           = busy_q[resp_id_i] & ~rst_i;
  assign demux_sel_o   = hit ? port_q[resp_id_i] : '0;
  assign demux_valid_o = resp_valid_i & hit;
  assign resp_ready_o  = hit ? demux_ready_i : 1'b1;

  assign alloc      = req_valid_i & req_ready_o;
  assign release_id = resp_valid_i & hit & demux_ready_i & resp_last_i;

  assign outstanding_o = rst_i ? '0 : cnt_q;
  assign err_o         = err_q & ~rst_i;

  always_comb begin
    busy_d = busy_q;
    port_d = port_q;
    if (alloc) begin
      busy_d[req_id_o] = 1'b1;
      port_d[req_id_o] = req_portid_i;
    end
    // Alloc chose a free ID, so it can never collide with the released one.
    if (release_id) busy_d[resp_id_i] = 1'b0;
    cnt_d = cnt_q + (ID_WIDTH + 1)'(alloc) - (ID_WIDTH + 1)'(release_id);
    err_d = resp_valid_i & ~hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      port_q <= '{default: '0};
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      port_q <= port_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_hpdcache_l15_resp_route_table.sv
// Directed, table-driven bench for the L1.5 response route table.
module tb_hpdcache_l15_resp_route_table;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_portid;
  logic [2:0] req_id;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_id;
  logic       resp_last;
  logic       demux_valid;
  logic [1:0] demux_sel;
  logic       demux_ready;
  logic [3:0] outstanding;
  logic       err;

  always #5 clk = ~clk;

  hpdcache_l15_resp_route_table #(
    .N_PORTS (4),
    .ID_WIDTH(3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_portid_i (req_portid),
    .req_id_o     (req_id),
    .resp_valid_i (resp_valid),
    .resp_ready_o (resp_ready),
    .resp_id_i    (resp_id),
    .resp_last_i  (resp_last),
    .demux_valid_o(demux_valid),
    .demux_sel_o  (demux_sel),
    .demux_ready_i(demux_ready),
    .outstanding_o(outstanding),
    .err_o        (err)
  );

  typedef struct {
    logic       rst;
    logic       rv;
    logic [1:0] pid;
    logic       sv;
    logic [2:0] sid;
    logic       last;
    logic       dr;
    logic       e_rr;
    logic [2:0] e_rid;
    logic       e_rsr;
    logic       e_dv;
    logic [1:0] e_ds;
    logic [3:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic r, input logic rv, input logic [1:0] pid, input logic sv,
                     input logic [2:0] sid, input logic last, input logic dr, input logic e_rr,
                     input logic [2:0] e_rid, input logic e_rsr, input logic e_dv,
                     input logic [1:0] e_ds, input logic [3:0] e_out, input logic e_err);
    vec_t v;
    v.rst = r;  v.rv = rv; v.pid = pid; v.sv = sv; v.sid = sid; v.last = last; v.dr = dr;
    v.e_rr = e_rr; v.e_rid = e_rid; v.e_rsr = e_rsr; v.e_dv = e_dv; v.e_ds = e_ds;
    v.e_out = e_out; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp);
  endtask

  task automatic drive(input logic r, input logic rv, input logic [1:0] pid, input logic sv,
                       input logic [2:0] sid, input logic last, input logic dr);
    rst = r; req_valid = rv; req_portid = pid;
    resp_valid = sv; resp_id = sid; resp_last = last; demux_ready = dr;
  endtask

  initial begin
    int n;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);

    //  rst rv pid sv sid lst dr | rr rid rsr dv ds out err
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 6, 1, 1,   0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 2'(i % 4), 0, 0, 0, 1, 1, 3'(i), 1, 0, 0, 4'(i), 0);
    add(0, 0, 0, 1, 5, 1, 1,   0, 0, 1, 1, 1, 8, 0);  // release id 5 (port 1)
    add(0, 0, 0, 0, 0, 0, 1,   1, 5, 1, 0, 0, 7, 0);
    add(0, 1, 3, 0, 0, 0, 1,   1, 5, 1, 0, 0, 7, 0);  // realloc id 5 to port 3
    add(0, 0, 0, 0, 5, 0, 0,   0, 0, 0, 0, 3, 8, 0);
    add(0, 0, 0, 1, 2, 0, 1,   0, 0, 1, 1, 2, 8, 0);  // 4-beat burst on id 2
    add(0, 0, 0, 1, 2, 0, 0,   0, 0, 0, 1, 2, 8, 0);
    add(0, 0, 0, 1, 2, 0, 0,   0, 0, 0, 1, 2, 8, 0);
    add(0, 0, 0, 1, 2, 0, 1,   0, 0, 1, 1, 2, 8, 0);
    add(0, 0, 0, 1, 2, 0, 1,   0, 0, 1, 1, 2, 8, 0);
    add(0, 0, 0, 1, 2, 1, 0,   0, 0, 0, 1, 2, 8, 0);
    add(0, 0, 0, 1, 2, 1, 1,   0, 0, 1, 1, 2, 8, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 2, 1, 0, 0, 7, 0);
    add(0, 1, 2, 0, 0, 0, 1,   1, 2, 1, 0, 0, 7, 0);
    add(0, 1, 1, 1, 3, 1, 1,   0, 0, 1, 1, 3, 8, 0);  // release while full + req
    add(0, 1, 0, 0, 0, 0, 1,   1, 3, 1, 0, 0, 7, 0);
    add(0, 0, 0, 1, 6, 1, 1,   0, 0, 1, 1, 2, 8, 0);
    add(0, 0, 0, 1, 6, 1, 0,   1, 6, 1, 0, 0, 7, 0);  // unallocated id 6
    add(0, 0, 0, 0, 0, 0, 1,   1, 6, 1, 0, 0, 7, 1);
    add(0, 0, 0, 1, 0, 1, 1,   1, 6, 1, 1, 0, 7, 0);
    add(0, 0, 0, 1, 4, 1, 1,   1, 0, 1, 1, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0);  // reset with 5 outstanding
    add(0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 0, 0, 0, 0);  // late response to forgotten id
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].rv, vecs[k].pid, vecs[k].sv, vecs[k].sid, vecs[k].last,
            vecs[k].dr);
      #1;
      chk("req_ready",   k, int'(req_ready),   int'(vecs[k].e_rr));
      chk("req_id",      k, int'(req_id),      int'(vecs[k].e_rid));
      chk("resp_ready",  k, int'(resp_ready),  int'(vecs[k].e_rsr));
      chk("demux_valid", k, int'(demux_valid), int'(vecs[k].e_dv));
      chk("demux_sel",   k, int'(demux_sel),   int'(vecs[k].e_ds));
      chk("outstanding", k, int'(outstanding), int'(vecs[k].e_out));
      chk("err",         k, int'(err),         int'(vecs[k].e_err));
    end

    // Fill from empty with a bounded loop; ready must drop after exactly 8 grants.
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'(c % 4), 1'b0, 3'd0, 1'b0, 1'b1);
      #1;
      if (!req_ready) break;
      chk("fill_id", c, int'(req_id), n);
      n++;
    end
    chk("fill_count", 0, n, 8);
    chk("fill_ready", 0, int'(req_ready), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    #1;
    chk("fill_outstanding", 0, int'(outstanding), 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
